muldiv_seq: RTL

- Multi-cycle RV32M multiply/divide sequencer that sits beside the single-cycle ALU in the execute stage.
- Accepts one operation on a start pulse and asserts busy while it runs; the control unit uses busy to stall the pipeline.
- Iterates a shift-add multiply or a restoring divide over WIDTH cycles, then pulses done with the result.
- Operation select is funct3 of the OP/M instruction.

---
 rtl/muldiv_seq_if.sv | 24 ++
 rtl/muldiv_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// Handshake and operand bus between the execute-stage control unit and the
// multi-cycle multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             kill;
    logic [2:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, kill, op, opA, opB,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, op, opA, opB,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: shift-add multiply or restoring divide on
// operand magnitudes over WIDTH iterations, with sign fix-up at the end.
//
// state | meaning
// IDLE  | waiting for start
// PREP  | record signs, take magnitudes, clear accumulator and counter
// CALC  | one multiply/divide iteration per cycle, WIDTH cycles
// FIX   | sign-correct and register the selected result field
// DONE  | done pulse; a new start may be accepted here
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic [WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   result_q;

    logic               accept, div_zero, cnt_last, is_div;
    logic               sign_a_en, sign_b_en;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               no_borrow;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fix_result;

    assign accept   = (state == IDLE || state == DONE) && bus.start && !bus.kill;
    assign div_zero = bus.op[2] && (bus.opB == '0);
    assign cnt_last = (cnt == CNT_W'(WIDTH - 1));
    assign is_div   = op_q[2];

    assign bus.busy   = (state == PREP) || (state == CALC) || (state == FIX);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; kill overrides everything, including a start.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = div_zero ? DONE : PREP;
            PREP:    state_nxt = CALC;
            CALC:    if (cnt_last) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = accept ? (div_zero ? DONE : PREP) : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.kill) state_nxt = IDLE;
    end

    // Operand conditioning and per-iteration arithmetic.
    always_comb begin
        // MULH, MULHSU, DIV, REM treat opA as signed; MULH, DIV, REM treat opB as signed.
        sign_a_en = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
        sign_b_en = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
        mag_a     = (sign_a_en && opa_q[WIDTH-1]) ? -opa_q : opa_q;
        mag_b     = (sign_b_en && opb_q[WIDTH-1]) ? -opb_q : opb_q;

        // prod = {accumulator, multiplier}; the carry out of the add shifts into the top bit.
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        mul_next  = prod[0] ? {mul_sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};

        // prod = {remainder, quotient}; the shifted remainder needs one extra bit.
        rem_sh    = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        rem_diff  = rem_sh - {1'b0, addend};
        no_borrow = (rem_sh >= {1'b0, addend});
        div_next  = no_borrow ? {rem_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1}
                              : {rem_sh[WIDTH-1:0],   prod[WIDTH-2:0], 1'b0};

        prod_fix  = (sign_a ^ sign_b) ? -prod : prod;
        quot_fix  = (sign_a ^ sign_b) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        rem_fix   = sign_a ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];

        case (op_q)
            3'b000:                 fix_result = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_result = quot_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    // Datapath registers: operand capture, iteration, and result update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            addend   <= '0;
            prod     <= '0;
            cnt      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus.op;
                opa_q <= bus.opA;
                opb_q <= bus.opB;
                // Zero divisor skips the datapath entirely.
                if (div_zero) result_q <= bus.op[1] ? bus.opA : '1;
            end
            case (state)
                PREP: begin
                    sign_a <= sign_a_en && opa_q[WIDTH-1];
                    sign_b <= sign_b_en && opb_q[WIDTH-1];
                    addend <= is_div ? mag_b : mag_a;
                    prod   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    cnt    <= '0;
                end
                CALC: begin
                    prod <= is_div ? div_next : mul_next;
                    cnt  <= cnt + 1'b1;
                end
                FIX: if (!bus.kill) result_q <= fix_result;
                default: ;
            endcase
        end
    end
endmodule
